// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bin2bcd_seq_if : handshake bundle for the iterative BCD converter |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
interface bin2bcd_seq_if #(
  parameter int DECLEN = 9,
  parameter int BINLEN = 30
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BINLEN-1:0]     BIN;
  logic                  out_valid;
  logic                  out_ready;
  logic [DECLEN*4-1:0]   BCD;
  logic                  ovf;
  logic                  busy;

  modport master (
    output in_valid, BIN, out_ready,
    input  in_ready, out_valid, BCD, ovf, busy
  );

  modport slave (
    input  in_valid, BIN, out_ready,
    output in_ready, out_valid, BCD, ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bin2bcd_seq : one-bit-per-clock double-dabble BCD converter       |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module bin2bcd_seq #(
  parameter int DECLEN = 9,
  parameter int BINLEN = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int c_DW = 4 * DECLEN;
  localparam int c_CW = (BINLEN > c_DW) ? BINLEN : c_DW;
  localparam int c_NW = $clog2(BINLEN + 1);

  // 10**DECLEN always fits in 4*DECLEN bits, so c_CW holds both operands.
  function automatic logic [c_CW-1:0] f_pow10(input int n);
    logic [c_CW-1:0] p;
    p = c_CW'(1);
    for (int k = 0; k < n; k++) p = (p << 3) + (p << 1);
    return p;
  endfunction

  localparam logic [c_CW-1:0] c_POW10 = f_pow10(DECLEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [BINLEN-1:0]   r_opnd;
  logic [c_DW-1:0]     r_acc;
  logic [c_NW-1:0]     r_cnt;
  logic                r_ovf_cap;
  logic [c_DW-1:0]     r_bcd;
  logic                r_ovf;
  logic [c_DW-1:0]     w_adj;
  logic [c_DW-1:0]     w_acc_sh;
  logic                w_ovf;

  // When 10**DECLEN >= 2**BINLEN this compare folds to constant 0.
  assign w_ovf = (c_CW'(bus.BIN) >= c_POW10);

  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < DECLEN; k++) begin
      if (r_acc[4*k +: 4] > 4'd4) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
    end
  end

  assign w_acc_sh = {w_adj[c_DW-2:0], r_opnd[BINLEN-1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = SHIFT;
      SHIFT:   if (r_cnt == c_NW'(1)) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_opnd    <= bus.BIN;
            r_acc     <= '0;
            r_cnt     <= c_NW'(BINLEN);
            r_ovf_cap <= w_ovf;
          end
        end
        SHIFT: begin
          r_acc  <= w_acc_sh;
          r_opnd <= {r_opnd[BINLEN-2:0], 1'b0};
          r_cnt  <= r_cnt - c_NW'(1);
          // Published outputs change only here, so they stay put outside DONE.
          if (r_cnt == c_NW'(1)) begin
            r_bcd <= w_acc_sh;
            r_ovf <= r_ovf_cap;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state == SHIFT);
  assign bus.out_valid = (r_state == DONE);
  assign bus.BCD       = r_bcd;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
